// File: rtl/lbctrl_pkg.sv
// Shared definitions for the line-buffer sequencer: FSM encodings and
// elaboration-time helpers.
package lbctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_STREAM = 3'd1;
    localparam state_t ST_DRAIN  = 3'd2;
    localparam state_t ST_LCLR   = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    function automatic int clog2(input int value);
        int result = 0;
        int rem = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // One FIFO per kernel row except the live row.
    function automatic int num_fifo(input int kernel);
        return kernel - 1;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Raster pixel handshake between the pixel source and the line-buffer sequencer.
interface line_buffer_ctrl_if;

    logic LBCTRL_Pix_valid;
    logic LBCTRL_Pix_ready;

    modport master (output LBCTRL_Pix_valid, input LBCTRL_Pix_ready);
    modport slave  (input LBCTRL_Pix_valid, output LBCTRL_Pix_ready);

endinterface

// File: rtl/line_buffer_ctrl.sv
// Sequencer for a cascade of KERNEL-1 row FIFOs: accepts a raster stream,
// drives FIFO enables/pointer clear and flags valid kernel columns/windows.
module line_buffer_ctrl
    import lbctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 480,
    parameter int KERNEL     = 3,
    parameter int ADDR_WIDTH = 10,
    parameter int ROW_WIDTH  = 9,
    localparam int NUM_FIFO  = num_fifo(KERNEL)
) (
    input  logic                  LBCTRL_Clk,
    input  logic                  LBCTRL_Reset,
    input  logic                  LBCTRL_Start,
    line_buffer_ctrl_if.slave     pix,
    output logic [NUM_FIFO-1:0]   LBCTRL_Fifo_Wen,
    output logic [NUM_FIFO-1:0]   LBCTRL_Fifo_Ren,
    output logic [NUM_FIFO-1:0]   LBCTRL_Fifo_Rdinc,
    output logic                  LBCTRL_Fifo_Ptrclr,
    output logic                  LBCTRL_Col_valid,
    output logic                  LBCTRL_Win_valid,
    output logic [ROW_WIDTH-1:0]  LBCTRL_Win_row,
    output logic [ADDR_WIDTH-1:0] LBCTRL_Win_col,
    output logic                  LBCTRL_Frame_done
);

    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0]  ROW_LAST = ROW_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [ROW_WIDTH-1:0]  ROW_FULL = ROW_WIDTH'(KERNEL - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_FULL = ADDR_WIDTH'(KERNEL - 1);

    state_t                  state_reg;
    state_t                  state_next;
    logic                    ptrclr_reg;
    logic [ADDR_WIDTH-1:0]   col_reg;
    logic [ROW_WIDTH-1:0]    row_reg;
    logic                    accept_d1_reg;
    logic [ADDR_WIDTH-1:0]   col_d1_reg;
    logic [ROW_WIDTH-1:0]    row_d1_reg;

    logic pix_ready;
    logic frame_done;
    logic accept;
    logic last_col;
    logic last_row;

    assign accept   = pix.LBCTRL_Pix_valid & pix_ready;
    assign last_col = (col_reg == COL_LAST);
    assign last_row = (row_reg == ROW_LAST);

    always_ff @(posedge LBCTRL_Clk) begin
        if (LBCTRL_Reset) begin
            state_reg  <= ST_IDLE;
            ptrclr_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            // Registered from the next state so the clear line never glitches.
            ptrclr_reg <= (state_next == ST_STREAM) || (state_next == ST_DRAIN);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (LBCTRL_Start) state_next = ST_STREAM;
            ST_STREAM: if (accept && last_col) state_next = ST_DRAIN;
            ST_DRAIN:  state_next = ST_LCLR;
            ST_LCLR:   state_next = last_row ? ST_DONE : ST_STREAM;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            ST_STREAM: pix_ready  = 1'b1;
            ST_DONE:   frame_done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge LBCTRL_Clk) begin
        if (LBCTRL_Reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            if (accept) begin
                col_reg <= last_col ? '0 : col_reg + 1'b1;
            end
            if (state_reg == ST_LCLR) begin
                row_reg <= last_row ? '0 : row_reg + 1'b1;
            end
        end
    end

    // Coordinates of the pixel whose column appears on the FIFO outputs next cycle.
    always_ff @(posedge LBCTRL_Clk) begin
        if (LBCTRL_Reset) begin
            accept_d1_reg <= 1'b0;
            col_d1_reg    <= '0;
            row_d1_reg    <= '0;
        end else begin
            accept_d1_reg <= accept;
            if (accept) begin
                col_d1_reg <= col_reg;
                row_d1_reg <= row_reg;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIFO; gi++) begin : g_fifo
            assign LBCTRL_Fifo_Ren[gi]   = accept & (row_reg >= ROW_WIDTH'(gi + 1));
            assign LBCTRL_Fifo_Rdinc[gi] = LBCTRL_Fifo_Ren[gi];
            if (gi == 0) begin : g_head
                assign LBCTRL_Fifo_Wen[gi] = accept;
            end else begin : g_cascade
                // Takes FIFO gi-1's registered output one cycle after its read.
                assign LBCTRL_Fifo_Wen[gi] = accept_d1_reg & (row_d1_reg >= ROW_WIDTH'(gi));
            end
        end
    endgenerate

    assign pix.LBCTRL_Pix_ready = pix_ready;
    assign LBCTRL_Frame_done    = frame_done;
    assign LBCTRL_Fifo_Ptrclr   = ptrclr_reg;
    assign LBCTRL_Col_valid     = accept_d1_reg & (row_d1_reg >= ROW_FULL);
    assign LBCTRL_Win_valid     = LBCTRL_Col_valid & (col_d1_reg >= COL_FULL);
    assign LBCTRL_Win_row       = row_d1_reg;
    assign LBCTRL_Win_col       = col_d1_reg;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl on a 4x4 image with a 3x3 kernel, using behavioural
// row FIFOs and a frame-level expectation model.
module tb_line_buffer_ctrl;
    import lbctrl_pkg::*;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int K     = 3;
    localparam int AW    = 10;
    localparam int RW    = 9;
    localparam int NF    = num_fifo(K);
    localparam int TOTAL = W * H;
    localparam int DEPTH = 8;
    localparam int PW    = clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    pix_data = 8'h00;
    logic [NF-1:0] wen, ren, rdinc;
    logic          ptrclr, col_valid, win_valid, frame_done;
    logic [RW-1:0] win_row;
    logic [AW-1:0] win_col;

    line_buffer_ctrl_if pix ();

    line_buffer_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K), .ADDR_WIDTH(AW), .ROW_WIDTH(RW)
    ) dut (
        .LBCTRL_Clk(clk),
        .LBCTRL_Reset(rst),
        .LBCTRL_Start(start),
        .pix(pix),
        .LBCTRL_Fifo_Wen(wen),
        .LBCTRL_Fifo_Ren(ren),
        .LBCTRL_Fifo_Rdinc(rdinc),
        .LBCTRL_Fifo_Ptrclr(ptrclr),
        .LBCTRL_Col_valid(col_valid),
        .LBCTRL_Win_valid(win_valid),
        .LBCTRL_Win_row(win_row),
        .LBCTRL_Win_col(win_col),
        .LBCTRL_Frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Row FIFOs: a same-cycle read and write of one address returns the old word.
    logic [7:0]    fmem [NF][DEPTH];
    logic [PW-1:0] fwr [NF];
    logic [PW-1:0] frd [NF];
    logic [7:0]    fout [NF];
    logic [7:0]    pix_d1;

    always @(posedge clk) begin
        if (wen[0]) pix_d1 <= pix_data;
        for (int k = 0; k < NF; k++) begin
            if (!ptrclr) begin
                fwr[k] <= '0;
                frd[k] <= '0;
            end else begin
                if (wen[k]) begin
                    fmem[k][fwr[k]] <= (k == 0) ? pix_data : fout[(k == 0) ? 0 : k - 1];
                    fwr[k] <= fwr[k] + 1'b1;
                end
                if (ren[k])   fout[k] <= fmem[k][frd[k]];
                if (rdinc[k]) frd[k]  <= frd[k] + 1'b1;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    // Frame-level expectation: accepted pixel count, idle gap after each row,
    // and the last accepted pixel.
    bit started = 1'b0;
    bit done_due = 1'b0;
    int gap = 0;
    int n_acc = 0;
    bit prev_acc = 1'b0;
    int prev_row = 0;
    int prev_col = 0;
    int img [H][W];

    int cyc = 0;
    int win_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int dut_acc = 0;
    int win_q[$];
    int ptr_low_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit acc, idle_now, e_ready, e_ptr, e_cv, e_wv, e_done;
        logic [NF-1:0] e_wen, e_ren;
        int r, c;
        @(negedge clk);
        r = n_acc / W;
        c = n_acc % W;
        e_ready = started && gap == 0 && n_acc < TOTAL;
        e_done  = done_due;
        e_ptr   = started && gap != 1 && !done_due;
        acc     = pix.LBCTRL_Pix_valid && e_ready;
        for (int k = 0; k < NF; k++) begin
            e_ren[k] = acc && r >= k + 1;
            e_wen[k] = (k == 0) ? acc : (prev_acc && prev_row >= k);
        end
        e_cv = prev_acc && prev_row >= K - 1;
        e_wv = e_cv && prev_col >= K - 1;

        chk("pix_ready", pix.LBCTRL_Pix_ready, e_ready);
        chk("ptrclr", ptrclr, e_ptr);
        chk("frame_done", frame_done, e_done);
        chk("wen", wen, e_wen);
        chk("ren", ren, e_ren);
        chk("rdinc", rdinc, e_ren);
        chk("col_valid", col_valid, e_cv);
        chk("win_valid", win_valid, e_wv);
        if (e_cv) begin
            for (int k = 0; k < NF; k++)
                chk($sformatf("fifo%0d_out", k), fout[k], img[prev_row - 1 - k][prev_col]);
            chk("pix_delayed", pix_d1, img[prev_row][prev_col]);
        end
        if (e_wv) begin
            chk("win_row", win_row, prev_row);
            chk("win_col", win_col, prev_col);
        end

        if (win_valid === 1'b1) begin
            win_cnt++;
            win_q.push_back(100 * int'(win_row) + int'(win_col));
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ptrclr === 1'b0 && started && !done_due) ptr_low_q.push_back(cyc);
        if (pix.LBCTRL_Pix_valid === 1'b1 && pix.LBCTRL_Pix_ready === 1'b1) dut_acc++;

        if (rst) begin
            started = 0; done_due = 0; gap = 0; n_acc = 0;
            prev_acc = 0; prev_row = 0; prev_col = 0;
        end else begin
            idle_now = !started && !done_due;
            prev_acc = acc;
            if (acc) begin
                prev_row = r;
                prev_col = c;
            end
            if (done_due) begin
                done_due = 0;
                started = 0;
            end else if (gap > 0) begin
                gap--;
                if (gap == 0 && n_acc == TOTAL) done_due = 1;
            end
            if (acc) begin
                n_acc++;
                if (c == W - 1) gap = 2;
            end
            if (start && idle_now) begin
                started = 1;
                n_acc = 0;
                gap = 0;
            end
        end
        $display("cyc=%0d valid=%0b ready=%0b wen=%b ren=%b ptrclr=%0b win=%0b(%0d,%0d) done=%0b",
                 cyc, pix.LBCTRL_Pix_valid, pix.LBCTRL_Pix_ready, wen, ren, ptrclr,
                 win_valid, win_row, win_col, frame_done);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // vmode 0: ramp image, valid held; 1: random image, valid toggling; 2: random both.
    task automatic run_frame(input int vmode, input int rst_at, input bit start_noise,
                             output bit aborted);
        int budget = 400;
        bit fin = 0;
        aborted = 0;
        win_cnt = 0; done_cnt = 0; dut_acc = 0; done_cyc = -1; cyc = 0;
        win_q.delete();
        ptr_low_q.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (vmode == 0) ? r * W + c : int'($urandom_range(0, 255));
        while (!fin && budget > 0) begin
            start = (cyc == 0) || (start_noise && started && $urandom_range(0, 2) == 0);
            case (vmode)
                0:       pix.LBCTRL_Pix_valid = 1'b1;
                1:       pix.LBCTRL_Pix_valid = (cyc % 2 == 1);
                default: pix.LBCTRL_Pix_valid = 1'($urandom_range(0, 1));
            endcase
            pix_data = (n_acc < TOTAL) ? 8'(img[n_acc / W][n_acc % W]) : 8'h00;
            rst = (rst_at >= 0 && n_acc == rst_at && started && gap == 0);
            if (rst) aborted = 1;
            tick();
            if (aborted) begin
                rst = 1'b0;
                fin = 1;
            end else if (cyc > 1 && !started && !done_due) begin
                fin = 1;
            end
            budget--;
        end
        start = 1'b0;
        pix.LBCTRL_Pix_valid = 1'b0;
        chk("frame_timeout", fin, 1);
    endtask

    task automatic check_windows(input string tag);
        int exp_q[$];
        for (int r = K - 1; r < H; r++)
            for (int c = K - 1; c < W; c++)
                exp_q.push_back(100 * r + c);
        chk({tag, "_win_cnt"}, win_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < win_q.size(); i++)
            chk({tag, "_win_pos"}, win_q[i], exp_q[i]);
    endtask

    initial begin
        bit aborted;
        pix.LBCTRL_Pix_valid = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        start = 1'b0;
        tick();

        run_frame(0, -1, 0, aborted);
        chk("a_done_cycle", done_cyc, 25);
        chk("a_done_cnt", done_cnt, 1);
        chk("a_accepts", dut_acc, TOTAL);
        chk("a_ptrclr_low_cnt", ptr_low_q.size(), 4);
        for (int i = 0; i < 4 && i < ptr_low_q.size(); i++)
            chk("a_ptrclr_low_cyc", ptr_low_q[i], 6 * (i + 1));
        check_windows("a");
        tick();

        run_frame(1, -1, 0, aborted);
        chk("b_done_cnt", done_cnt, 1);
        chk("b_accepts", dut_acc, TOTAL);
        check_windows("b");

        run_frame(2, -1, 1, aborted);
        chk("c_done_cnt", done_cnt, 1);
        chk("c_accepts", dut_acc, TOTAL);
        check_windows("c");

        run_frame(2, 2 * W + 1, 0, aborted);
        chk("d_aborted", aborted, 1);
        @(negedge clk);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_ptrclr", ptrclr, 0);
        chk("rst_ready", pix.LBCTRL_Pix_ready, 0);
        chk("rst_wen", wen, 0);
        chk("rst_ren", ren, 0);
        chk("rst_rdinc", rdinc, 0);
        chk("rst_col_valid", col_valid, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk);
        #1;

        run_frame(2, -1, 1, aborted);
        chk("e_done_cnt", done_cnt, 1);
        chk("e_accepts", dut_acc, TOTAL);
        check_windows("e");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
